mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one memory port between an instruction-fetch requester and a data
// requester. One transaction runs at a time: IDLE arbitrates and latches the
// winner's fields, ISSUE presents the request to memory until it is
// accepted, WAIT collects read data (bounded by TIMEOUT), and RESP returns a
// one-cycle ack to the granted port.
//
// Ports
//   Clk, Rst_N        clock, asynchronous active-low reset
//   in_if_*           fetch request (always a 32-bit read)
//   out_if_*          fetch ack pulse, instruction, error
//   in_dm_*           data request (read or byte-enabled write)
//   out_dm_*          data ack pulse, read data, error
//   out_mem_*         request to memory (doubleword-aligned address)
//   in_mem_*          memory accept / read-data return
//   out_busy          high whenever a transaction is in progress
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        Clk,
    input  logic        Rst_N,
    input  logic        in_if_req,
    input  logic [63:0] in_if_addr,
    output logic        out_if_ack,
    output logic [31:0] out_if_inst,
    output logic        out_if_err,
    input  logic        in_dm_req,
    input  logic        in_dm_we,
    input  logic [63:0] in_dm_addr,
    input  logic [63:0] in_dm_wr_data,
    input  logic [7:0]  in_dm_be,
    output logic        out_dm_ack,
    output logic [63:0] out_dm_rd_data,
    output logic        out_dm_err,
    output logic        out_mem_req,
    output logic        out_mem_we,
    output logic [63:0] out_mem_addr,
    output logic [63:0] out_mem_wr_data,
    output logic [7:0]  out_mem_be,
    input  logic        in_mem_ready,
    input  logic        in_mem_rvalid,
    input  logic [63:0] in_mem_rd_data,
    output logic        out_busy
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_last_grant;   // 1 = data port won last, 0 = fetch
    logic        r_gnt_dm;       // port owning the current transaction
    logic        r_we;
    logic [63:0] r_addr;
    logic [63:0] r_wr_data;
    logic [7:0]  r_be;
    logic [7:0]  r_cnt;
    logic        r_mem_req;
    logic        r_if_ack;
    logic        r_if_err;
    logic [31:0] r_if_inst;
    logic        r_dm_ack;
    logic        r_dm_err;
    logic [63:0] r_dm_rd_data;

    // Data wins if it is the only requester, or on a tie when fetch won last.
    logic w_pick_dm;
    logic w_if_misaligned;
    logic w_timeout;

    assign w_pick_dm       = in_dm_req && (!in_if_req || !r_last_grant);
    assign w_if_misaligned = (in_if_addr[1:0] != 2'b00);
    assign w_timeout       = ((r_cnt + 8'd1) == TIMEOUT_C);

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b0;
            r_gnt_dm     <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wr_data    <= '0;
            r_be         <= '0;
            r_cnt        <= '0;
            r_mem_req    <= 1'b0;
            r_if_ack     <= 1'b0;
            r_if_err     <= 1'b0;
            r_if_inst    <= '0;
            r_dm_ack     <= 1'b0;
            r_dm_err     <= 1'b0;
            r_dm_rd_data <= '0;
        end else begin
            // Acks are single-cycle pulses; only the RESP entry raises them.
            r_if_ack <= 1'b0;
            r_dm_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_if_req || in_dm_req) begin
                        r_gnt_dm     <= w_pick_dm;
                        r_last_grant <= w_pick_dm;
                        if (w_pick_dm) begin
                            r_we      <= in_dm_we;
                            r_addr    <= in_dm_addr;
                            r_wr_data <= in_dm_wr_data;
                            r_be      <= in_dm_be;
                            r_mem_req <= 1'b1;
                            r_state   <= ST_ISSUE;
                        end else begin
                            r_we      <= 1'b0;
                            r_addr    <= in_if_addr;
                            r_wr_data <= '0;
                            r_be      <= 8'hFF;
                            // A misaligned fetch never reaches memory.
                            if (w_if_misaligned) begin
                                r_if_ack <= 1'b1;
                                r_if_err <= 1'b1;
                                r_state  <= ST_RESP;
                            end else begin
                                r_mem_req <= 1'b1;
                                r_state   <= ST_ISSUE;
                            end
                        end
                    end
                end
                ST_ISSUE: begin
                    if (in_mem_ready) begin
                        r_mem_req <= 1'b0;
                        r_cnt     <= '0;
                        if (r_we) begin
                            // Only the data port can write.
                            r_dm_ack <= 1'b1;
                            r_dm_err <= 1'b0;
                            r_state  <= ST_RESP;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (in_mem_rvalid || w_timeout) begin
                        r_state <= ST_RESP;
                        if (r_gnt_dm) begin
                            r_dm_ack <= 1'b1;
                            r_dm_err <= !in_mem_rvalid;
                            if (in_mem_rvalid) begin
                                r_dm_rd_data <= in_mem_rd_data;
                            end
                        end else begin
                            r_if_ack <= 1'b1;
                            r_if_err <= !in_mem_rvalid;
                            if (in_mem_rvalid) begin
                                r_if_inst <= r_addr[2] ? in_mem_rd_data[63:32]
                                                       : in_mem_rd_data[31:0];
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_if_ack      = r_if_ack;
    assign out_if_inst     = r_if_inst;
    assign out_if_err      = r_if_err;
    assign out_dm_ack      = r_dm_ack;
    assign out_dm_rd_data  = r_dm_rd_data;
    assign out_dm_err      = r_dm_err;
    assign out_mem_req     = r_mem_req;
    assign out_mem_we      = r_we;
    assign out_mem_addr    = {r_addr[63:3], 3'b000};
    assign out_mem_wr_data = r_wr_data;
    assign out_mem_be      = r_be;
    assign out_busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int TO = 4;

    logic        Clk = 1'b0;
    logic        Rst_N = 1'b0;
    logic        in_if_req = 1'b0;
    logic [63:0] in_if_addr = '0;
    logic        out_if_ack;
    logic [31:0] out_if_inst;
    logic        out_if_err;
    logic        in_dm_req = 1'b0;
    logic        in_dm_we = 1'b0;
    logic [63:0] in_dm_addr = '0;
    logic [63:0] in_dm_wr_data = '0;
    logic [7:0]  in_dm_be = '0;
    logic        out_dm_ack;
    logic [63:0] out_dm_rd_data;
    logic        out_dm_err;
    logic        out_mem_req;
    logic        out_mem_we;
    logic [63:0] out_mem_addr;
    logic [63:0] out_mem_wr_data;
    logic [7:0]  out_mem_be;
    logic        in_mem_ready = 1'b0;
    logic        in_mem_rvalid = 1'b0;
    logic [63:0] in_mem_rd_data = '0;
    logic        out_busy;

    mem_port_arbiter #(.TIMEOUT(TO)) dut (
        .Clk(Clk), .Rst_N(Rst_N),
        .in_if_req(in_if_req), .in_if_addr(in_if_addr),
        .out_if_ack(out_if_ack), .out_if_inst(out_if_inst), .out_if_err(out_if_err),
        .in_dm_req(in_dm_req), .in_dm_we(in_dm_we), .in_dm_addr(in_dm_addr),
        .in_dm_wr_data(in_dm_wr_data), .in_dm_be(in_dm_be),
        .out_dm_ack(out_dm_ack), .out_dm_rd_data(out_dm_rd_data), .out_dm_err(out_dm_err),
        .out_mem_req(out_mem_req), .out_mem_we(out_mem_we), .out_mem_addr(out_mem_addr),
        .out_mem_wr_data(out_mem_wr_data), .out_mem_be(out_mem_be),
        .in_mem_ready(in_mem_ready), .in_mem_rvalid(in_mem_rvalid),
        .in_mem_rd_data(in_mem_rd_data), .out_busy(out_busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit          dm;
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  be;
        int          rdy;       // ISSUE cycles with ready low before accept
        int          rv;        // WAIT cycles without rvalid before data
        logic [63:0] rdata;
        int          exp_lat;
        bit          exp_err;
        logic [63:0] exp_data;
    } txn_t;

    int n_chk = 0;
    int n_err = 0;

    // Memory responder state
    int          resp_rdy;
    int          resp_rv;
    logic [63:0] resp_data;
    int          iss_cnt;
    int          wait_cnt;
    bit          accepted;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic txn_t mk(input bit dm, input bit we, input logic [63:0] addr,
                                input logic [63:0] wdata, input logic [7:0] be,
                                input int rdy, input int rv, input logic [63:0] rdata,
                                input int lat, input bit err, input logic [63:0] ed);
        txn_t t;
        t.dm = dm; t.we = we; t.addr = addr; t.wdata = wdata; t.be = be;
        t.rdy = rdy; t.rv = rv; t.rdata = rdata;
        t.exp_lat = lat; t.exp_err = err; t.exp_data = ed;
        return t;
    endfunction

    // Reference: latency/result from the transaction rules, cycle counts summed.
    function automatic txn_t model(input txn_t t);
        txn_t r;
        r = t;
        r.exp_data = '0;
        if (!t.dm && t.addr[1:0] != 2'b00) begin
            r.exp_lat = 2;                       // IDLE -> RESP
            r.exp_err = 1'b1;
        end else if (t.dm && t.we) begin
            r.exp_lat = 1 + (t.rdy + 1) + 1;     // IDLE, ISSUE.., RESP
            r.exp_err = 1'b0;
        end else if (t.rv >= TO) begin
            r.exp_lat = 1 + (t.rdy + 1) + TO + 1;
            r.exp_err = 1'b1;
        end else begin
            r.exp_lat = 1 + (t.rdy + 1) + (t.rv + 1) + 1;
            r.exp_err = 1'b0;
            if (t.dm) r.exp_data = t.rdata;
            else      r.exp_data = t.addr[2] ? {32'h0, t.rdata[63:32]} : {32'h0, t.rdata[31:0]};
        end
        return r;
    endfunction

    task automatic mem_idle();
        in_mem_ready   = 1'b0;
        in_mem_rvalid  = 1'b0;
        in_mem_rd_data = {$urandom, $urandom};
        accepted       = 1'b0;
        iss_cnt        = 0;
    endtask

    // Called once per cycle, just after sampling, to drive the memory side.
    task automatic mem_step();
        in_mem_ready   = 1'b0;
        in_mem_rvalid  = 1'b0;
        in_mem_rd_data = {$urandom, $urandom};
        if (accepted) begin
            if (wait_cnt == resp_rv) begin
                in_mem_rvalid  = 1'b1;
                in_mem_rd_data = resp_data;
                accepted       = 1'b0;
            end
            wait_cnt++;
        end
        if (out_mem_req) begin
            if (iss_cnt == resp_rdy) begin
                in_mem_ready = 1'b1;
                accepted     = !out_mem_we;
                wait_cnt     = 0;
                iss_cnt      = 0;
            end else begin
                iss_cnt++;
            end
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " if_ack"}, out_if_ack, 0);
        chk({tag, " dm_ack"}, out_dm_ack, 0);
        chk({tag, " if_err"}, out_if_err, 0);
        chk({tag, " dm_err"}, out_dm_err, 0);
        chk({tag, " mem_req"}, out_mem_req, 0);
        chk({tag, " busy"}, out_busy, 0);
        chk({tag, " if_inst"}, out_if_inst, 0);
        chk({tag, " dm_rd_data"}, out_dm_rd_data, 0);
        chk({tag, " mem_addr"}, out_mem_addr, 0);
        chk({tag, " mem_be/we/wdata"}, {out_mem_be, out_mem_we, out_mem_wr_data[54:0]}, 0);
    endtask

    task automatic run_txn(input txn_t t, input string nm);
        int          k;
        int          lat;
        bit          acked;
        bit          wrong_ack;
        bit          fld_bad;
        bit          saw_req;
        logic        err;
        logic [63:0] data;
        logic [7:0]  exp_be;
        bit          exp_we;
        bit          misal;
        exp_be = t.dm ? t.be : 8'hFF;
        exp_we = t.dm && t.we;
        misal  = !t.dm && (t.addr[1:0] != 2'b00);
        resp_rdy = t.rdy; resp_rv = t.rv; resp_data = t.rdata;
        accepted = 1'b0; iss_cnt = 0;
        if (t.dm) begin
            in_dm_req = 1'b1; in_dm_we = t.we; in_dm_addr = t.addr;
            in_dm_wr_data = t.wdata; in_dm_be = t.be;
        end else begin
            in_if_req = 1'b1; in_if_addr = t.addr;
        end
        k = 0; lat = -1; acked = 0; wrong_ack = 0; fld_bad = 0; saw_req = 0;
        err = 1'bx; data = 'x;
        while (!acked && k < 60) begin
            @(posedge Clk); #1;
            k++;
            if (t.dm ? out_if_ack : out_dm_ack) wrong_ack = 1;
            if (out_mem_req) begin
                saw_req = 1;
                if (out_mem_addr !== {t.addr[63:3], 3'b000} || out_mem_be !== exp_be ||
                    out_mem_we !== exp_we || (exp_we && out_mem_wr_data !== t.wdata))
                    fld_bad = 1;
            end
            if (t.dm ? out_dm_ack : out_if_ack) begin
                acked = 1;
                lat   = k + 1;
                err   = t.dm ? out_dm_err : out_if_err;
                data  = t.dm ? out_dm_rd_data : {32'h0, out_if_inst};
            end
            mem_step();
        end
        chk({nm, " latency"}, lat, t.exp_lat);
        chk({nm, " err"}, err, t.exp_err);
        chk({nm, " other port ack"}, wrong_ack, 0);
        if (misal) chk({nm, " mem_req issued"}, saw_req, 0);
        else       chk({nm, " mem fields"}, fld_bad, 0);
        if (!t.exp_err && !exp_we) chk({nm, " data"}, data, t.exp_data);
        // Requester keeps req through the ack cycle, drops it afterwards.
        @(posedge Clk); #1;
        chk({nm, " ack one cycle"}, {out_if_ack, out_dm_ack}, 0);
        chk({nm, " idle after resp"}, out_busy, 0);
        if (!t.exp_err && !exp_we)
            chk({nm, " data held"}, t.dm ? out_dm_rd_data : {32'h0, out_if_inst}, t.exp_data);
        in_if_req = 1'b0; in_dm_req = 1'b0;
        mem_idle();
        $display("txn %s port=%s we=%0d addr=0x%0h lat=%0d err=%0d data=0x%0h",
                 nm, t.dm ? "dm" : "if", t.we, t.addr, lat, err, data);
    endtask

    txn_t vec[10];
    bit   exp_ord[4];

    initial begin
        int          nack;
        bit          both;
        bit          bad;
        logic [63:0] x;
        txn_t        t;

        vec[0] = mk(1, 0, 64'h1000, 0, 8'hFF, 0, 0, 64'hDEADBEEF_CAFEF00D, 4, 0, 64'hDEADBEEF_CAFEF00D);
        vec[1] = mk(0, 0, 64'h2004, 0, 8'hFF, 0, 0, 64'h11111111_22222222, 4, 0, 64'h11111111);
        vec[2] = mk(0, 0, 64'h2000, 0, 8'hFF, 0, 0, 64'h11111111_22222222, 4, 0, 64'h22222222);
        vec[3] = mk(0, 0, 64'h2003, 0, 8'hFF, 0, 0, 64'h0, 2, 1, 0);
        vec[4] = mk(1, 1, 64'h300C, 64'h0123_4567_89AB_CDEF, 8'h0F, 5, 0, 0, 8, 0, 0);
        vec[5] = mk(1, 1, 64'h3010, 64'hFEDC_BA98_7654_3210, 8'hF0, 0, 0, 0, 3, 0, 0);
        vec[6] = mk(1, 0, 64'h4008, 0, 8'hFF, 0, 3, 64'h5555_6666_7777_8888, 7, 0, 64'h5555_6666_7777_8888);
        vec[7] = mk(1, 0, 64'h4010, 0, 8'hFF, 0, 99, 64'h1, 7, 1, 0);
        vec[8] = mk(0, 0, 64'h4020, 0, 8'hFF, 1, 4, 64'h2, 8, 1, 0);
        vec[9] = mk(0, 0, 64'h2002, 0, 8'hFF, 0, 0, 64'h0, 2, 1, 0);

        // Reset state
        mem_idle();
        #3;
        check_zero("reset");
        #19 Rst_N = 1'b1;
        @(posedge Clk); #1;

        // Tie from reset: data, fetch, data, fetch
        exp_ord = '{1'b1, 1'b0, 1'b1, 1'b0};
        resp_rdy = 0; resp_rv = 0; resp_data = 64'hA5A5_0000_5A5A_1111;
        in_if_addr = 64'h6000; in_dm_addr = 64'h7008; in_dm_we = 1'b0; in_dm_be = 8'hFF;
        in_if_req = 1'b1; in_dm_req = 1'b1;
        nack = 0; both = 0;
        for (int c = 0; c < 80 && nack < 4; c++) begin
            @(posedge Clk); #1;
            if (out_if_ack && out_dm_ack) both = 1;
            if (out_if_ack || out_dm_ack) begin
                chk($sformatf("tie grant %0d is dm", nack), out_dm_ack, exp_ord[nack]);
                $display("txn tie%0d port=%s", nack, out_dm_ack ? "dm" : "if");
                nack++;
            end
            mem_step();
        end
        chk("tie ack count", nack, 4);
        chk("tie double ack", both, 0);
        @(posedge Clk); #1;
        in_if_req = 1'b0; in_dm_req = 1'b0;
        mem_idle();

        // Directed table
        for (int i = 0; i < 10; i++) run_txn(vec[i], $sformatf("vec%0d", i));

        // Late rvalid after a timeout is ignored
        x = 64'h0BAD_F00D_1234_5678;
        run_txn(mk(1, 0, 64'h8000, 0, 8'hFF, 0, 1, x, 5, 0, x), "pre_late");
        run_txn(mk(0, 0, 64'h8100, 0, 8'hFF, 0, 99, 0, 7, 1, 0), "timeout_if");
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            in_mem_rvalid = 1'b1; in_mem_rd_data = 64'hFFFF_0000_FFFF_0000;
            @(posedge Clk); #1;
            if (out_if_ack || out_dm_ack || out_busy) bad = 1;
        end
        mem_idle();
        chk("late rvalid no activity", bad, 0);
        chk("late rvalid dm data held", out_dm_rd_data, x);
        run_txn(mk(0, 0, 64'h8104, 0, 8'hFF, 0, 0, 64'hCCCC_DDDD_EEEE_FFFF, 4, 0, 64'hCCCC_DDDD), "after_late");

        // Reset during WAIT
        resp_rdy = 0; resp_rv = 99; resp_data = 0; accepted = 0; iss_cnt = 0;
        in_dm_req = 1'b1; in_dm_we = 1'b0; in_dm_addr = 64'h9000; in_dm_be = 8'hFF;
        @(posedge Clk); #1; mem_step();
        @(posedge Clk); #1; mem_step();
        chk("busy before mid reset", out_busy, 1);
        #2 Rst_N = 1'b0;
        #1 check_zero("mid reset");
        in_dm_req = 1'b0;
        mem_idle();
        bad = 0;
        for (int c = 0; c < 2; c++) begin
            @(posedge Clk); #1;
            if (out_if_ack || out_dm_ack) bad = 1;
        end
        chk("no ack across reset", bad, 0);
        #3 Rst_N = 1'b1;
        @(posedge Clk); #1;
        run_txn(mk(1, 1, 64'h9008, 64'h1357_9BDF_2468_ACE0, 8'h3C, 1, 0, 0, 4, 0, 0), "post_rst_wr");
        run_txn(mk(1, 0, 64'h9010, 0, 8'hFF, 0, 0, 64'h7777_1111_2222_3333, 4, 0, 64'h7777_1111_2222_3333), "post_rst_rd");

        // Randomized transactions against the reference model
        for (int i = 0; i < 40; i++) begin
            bit          dm;
            logic [63:0] a;
            dm = $urandom_range(0, 1) == 1;
            a  = {$urandom, $urandom};
            if (!dm && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            t = mk(dm, dm ? ($urandom_range(0, 1) == 1) : 1'b0, a, {$urandom, $urandom},
                   8'($urandom_range(0, 255)), $urandom_range(0, 3), $urandom_range(0, 5),
                   {$urandom, $urandom}, 0, 0, 0);
            t = model(t);
            run_txn(t, $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
